alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequencing stage in front of the 16-bit LE/XOR ALU. Accepts operation requests over a valid/ready stream and registers them into an execute stage. The execute stage drives the combinational ALU, captures its result, and queues it in a small result FIFO for the downstream consumer. Tags are carried alongside each result, and illegal opcodes are flagged and counted.

## Interface
- `DEPTH`, 4: result FIFO entries. Power of two, ≥2.
- `TAG_W`, 4: width of the request tag carried with each operation.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted on this edge when `in_valid` is also high.
- `in_a`  in  16  operand A.
- `in_b`  in  16  operand B.
- `in_opcode`  in  4  `4'h4` = LE (A ≤ B, unsigned); `4'h5` = XOR.
- `in_tag`  in  `TAG_W`  opaque request ID.
- `alu_a`  out  16  operand A to the ALU.
- `alu_b`  out  16  operand B to the ALU.
- `alu_opcode`  out  4  opcode to the ALU.
- `alu_result`  in  16  combinational ALU result.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes the head on this edge when `out_valid` is also high.
- `out_result`  out  16  head result.
- `out_tag`  out  `TAG_W`  head tag.
- `out_illegal`  out  1  head request had an illegal opcode.
- `fifo_count`  out  `$clog2(DEPTH)+1`  FIFO occupancy.
- `illegal_cnt`  out  8  saturating count of illegal opcodes.

## Operation
- Execute register (EX) holds `ex_valid`, a, b, opcode, tag.
- **Accept:** on `in_valid && in_ready`, load EX and set `ex_valid`=1.
- **Ready:** `in_ready = !ex_valid || !fifo_full`. It does not depend on `out_ready`, so there is no combinational path from `out_ready` to `in_ready`.
- **ALU drive:** `alu_a`/`alu_b` come directly from the EX registers. `alu_opcode` is the EX opcode when `ex_valid`, else `4'h0`.
- **Push:** when `ex_valid && !fifo_full`, EX is pushed into the FIFO on that edge.
  - A legal opcode pushes `{alu_result, tag, illegal=0}`.
  - An illegal opcode (anything except 4 or 5) pushes `{16'h0000, tag, illegal=1}`, and `illegal_cnt` increments, saturating at 255.
- **EX update on push:** if a new request is accepted on the same edge, EX reloads; otherwise `ex_valid` clears.
- **Stall:** while the FIFO is full, EX holds its contents and `in_ready`=0.
- **Full-FIFO pop:** a push is blocked while full, even if a pop happens the same cycle; the push occurs on the next edge.
- **FIFO:** circular buffer with wrapping read/write pointers.
  - Simultaneous push and pop when not full and not empty: `fifo_count` is unchanged.
  - Pop when empty: ignored.
  - `out_*` show the head entry; when empty, `out_result`/`out_tag`/`out_illegal` are undefined and the bench must not check them.
- **Ordering:** results emerge strictly in acceptance order.

## Timing
- **Reset values** (asynchronous `rst_n` low): `ex_valid`=0; FIFO pointers 0; `fifo_count`=0; `illegal_cnt`=0.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `alu_opcode`=0.
  - EX data and FIFO storage are reset to 0.
- **Reset mid-operation:** all in-flight and queued entries are discarded. The first accept after deassertion behaves as from an idle state.
- **Latency:** request accepted at edge N → pushed at edge N+1 → `out_valid`=1 during cycle N+1 (the first cycle after edge N+1). Minimum is 2 edges from acceptance to the earliest pop.
- **Throughput:** one op per cycle while the FIFO is not full and the consumer drains.
- **Fill behaviour:** with `out_ready`=0, exactly `DEPTH`+1 requests are accepted (`DEPTH` in the FIFO, 1 in EX), then `in_ready` drops.
- **Counters:** `illegal_cnt` updates at the push edge. `fifo_count` updates at the push/pop edge.

## Test plan
- **Single LE op:** A=`16'h0003`, B=`16'h0005`, op=4, tag=2 → `out_valid` two edges after accept; `out_result`=`16'h0001`, tag=2, illegal=0.
- **Single XOR op:** A=`16'hF0F0`, B=`16'h0FF0`, op=5 → `out_result`=`16'hFF00`.
- **LE at the equality boundary:** A=B=`16'hFFFF`, op=4 → `16'h0001`.
- **Back-pressure** (`DEPTH`=4, `out_ready`=0, 8 requests offered back-to-back):
  - exactly 5 are accepted; `fifo_count`=4; `in_ready`=0.
  - Raising `out_ready` yields all 8 results in order with tags 0..7.
- **Illegal opcodes:** op=`4'h0` and op=`4'hF` → `out_result`=0 and `out_illegal`=1 for each; `illegal_cnt`=2. After 300 illegal ops, `illegal_cnt`=255.
- **Reset mid-stream:** assert `rst_n`=0 with 3 entries queued → `out_valid`=0, `fifo_count`=0, `in_ready`=1 immediately. A new op after release completes with the normal 2-edge latency.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/execute stage in front of the 16-bit LE/XOR ALU.
// A single EX register drives the ALU; its results go, tagged, into a small circular result FIFO.
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  input  logic [3:0]               in_opcode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [15:0]              alu_a,
  output logic [15:0]              alu_b,
  output logic [3:0]               alu_opcode,
  input  logic [15:0]              alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               illegal_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [3:0]  OP_LE  = 4'h4;
  localparam logic [3:0]  OP_XOR = 4'h5;

  typedef struct packed {
    logic [15:0]      result;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic             ex_valid;
  logic [15:0]      ex_a;
  logic [15:0]      ex_b;
  logic [3:0]       ex_op;
  logic [TAG_W-1:0] ex_tag;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       ill_cnt;

  logic   fifo_full;
  logic   fifo_empty;
  logic   accept;
  logic   push;
  logic   pop;
  logic   ex_illegal;
  entry_t push_entry;

  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = !ex_valid || !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = ex_valid && !fifo_full;
  assign pop        = out_ready && !fifo_empty;
  assign ex_illegal = (ex_op != OP_LE) && (ex_op != OP_XOR);

  assign alu_a      = ex_a;
  assign alu_b      = ex_b;
  assign alu_opcode = ex_valid ? ex_op : 4'h0;

  assign out_valid   = !fifo_empty;
  assign out_result  = mem[rd_ptr].result;
  assign out_tag     = mem[rd_ptr].tag;
  assign out_illegal = mem[rd_ptr].illegal;
  assign fifo_count  = count;
  assign illegal_cnt = ill_cnt;

  // Illegal opcodes bypass the ALU and carry a zero result.
  always_comb begin
    push_entry.result  = ex_illegal ? 16'h0000 : alu_result;
    push_entry.tag     = ex_tag;
    push_entry.illegal = ex_illegal;
  end

  // EX register: reload on accept, otherwise empty once pushed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_op    <= '0;
      ex_tag   <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_a     <= in_a;
      ex_b     <= in_b;
      ex_op    <= in_opcode;
      ex_tag   <= in_tag;
    end else if (push) begin
      ex_valid <= 1'b0;
    end
  end

  // Result FIFO storage and pointers; a push while full waits for the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating illegal-opcode counter, stepped at the push edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (push && ex_illegal && (ill_cnt != 8'hFF)) begin
      ill_cnt <= ill_cnt + 8'd1;
    end
  end

endmodule
